// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scan-code prefix bytes and frame geometry.
package ps2_pkg;

  // Device-to-host frame phases (the start bit is consumed by the IDLE exit).
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_t;

  // Scan-code set 2 prefixes: extended key and key release.
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Brings a raw, asynchronous PS/2 clock pin into the system clock domain,
// rejects glitches shorter than FILTER_LEN cycles and emits a one-cycle
// pulse on every accepted 1->0 transition of the filtered level.
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic pin,
  output logic fall
);

  localparam int            CW   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          meta;
  logic          sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; the idle level of a PS/2 line is high.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples; flag the falls.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync;
        cnt   <= '0;
        fall  <= ~sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host keyboard receiver. Deserializes 11-bit frames, checks
// start/parity/stop framing, folds E0 (extended) and F0 (release) prefixes
// into flags and reports one scan code per key event with a one-cycle strobe.
// Optional feature: define PS2_TIMEOUT_EN to abort frames whose PS/2 clock
// stalls for TIMEOUT_CYC system cycles (hot-plug / lost-edge recovery).
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
`ifdef PS2_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 50000
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_received,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic       fall;
  logic       dat_meta;
  logic       dat_sync;
  logic       timeout;
  ps2_state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic       par_bit;
  logic       ext_flag;
  logic       brk_flag;

  ps2_sync_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clock (clock),
    .resetn(resetn),
    .pin   (ps2_clk),
    .fall  (fall)
  );

  // Data pin only needs synchronizing: the device holds it stable across the
  // whole clock-low phase, and the filtered fall arrives well inside that window.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      dat_meta <= ps2_dat;
      dat_sync <= dat_meta;
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] idle_cnt;

  // Count system cycles since the last PS/2 clock fall while a frame is open.
  always_ff @(posedge clock) begin
    if (!resetn || state == IDLE || fall) begin
      idle_cnt <= '0;
    end else if (!timeout) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  // A fall in the same cycle restarts the count, so it overrides the abort.
  assign timeout = (idle_cnt == TW'(TIMEOUT_CYC - 1)) && !fall;
`else
  assign timeout = 1'b0;
`endif

  // Frame FSM, prefix folding and registered key-event outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      ps2_received <= '0;
      key_valid    <= 1'b0;
      key_break    <= 1'b0;
      key_ext      <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (timeout) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            // A high "start" bit is line noise or a lost frame tail: stay put.
            if (!dat_sync) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {dat_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= dat_sync;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_sync && odd_parity_ok(shift, par_bit)) begin
              if (shift == PS2_EXT) begin
                ext_flag <= 1'b1;
              end else if (shift == PS2_BREAK) begin
                brk_flag <= 1'b1;
              end else begin
                ps2_received <= shift;
                key_break    <= brk_flag;
                key_ext      <= ext_flag;
                key_valid    <= 1'b1;
                ext_flag     <= 1'b0;
                brk_flag     <= 1'b0;
              end
            end else begin
              // A corrupted byte may have been the key code the prefixes belonged to.
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver. Frames are driven with a PS/2
// clock scaled down to an 80-cycle period so the run stays short; data
// changes in the middle of the high phase as a real keyboard does.
module tb_ps2_key_receiver;

  localparam int HALF = 40;
`ifdef PS2_TIMEOUT_EN
  localparam int TO_CYC = 2000;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_received;
  logic       key_valid;
  logic       key_break;
  logic       key_ext;
  logic       frame_err;
  logic       busy;

  always #5 clock = ~clock;

  ps2_key_receiver #(
    .FILTER_LEN(8)
`ifdef PS2_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .ps2_clk     (ps2_clk),
    .ps2_dat     (ps2_dat),
    .ps2_received(ps2_received),
    .key_valid   (key_valid),
    .key_break   (key_break),
    .key_ext     (key_ext),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  typedef struct {
    logic [7:0] code;
    bit         brk;
    bit         ext;
  } key_t;

  // Model: pending key events / errors plus the values outputs must hold.
  key_t       key_q[$];
  int         err_pending;
  bit         m_ext, m_brk;
  logic [7:0] m_code;
  bit         m_kbrk, m_kext;
  key_t       cmp_k;

  int n_tests = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_err = 0;
  bit skip_cmp = 1'b1;
  bit prev_kv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    key_q.delete();
    err_pending = 0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_code = 8'h00;
    m_kbrk = 1'b0;
    m_kext = 1'b0;
  endfunction

  // Receiver rules from the byte stream: prefixes set flags, any other good
  // byte is a key event, any bad frame is an error that drops the flags.
  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      err_pending++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      key_q.push_back('{code: b, brk: m_brk, ext: m_ext});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  // Single compare process: strobes must match expected events, held outputs the model.
  always @(negedge clock) begin
    if (skip_cmp) begin
      prev_kv <= 1'b0;
    end else begin
      if (key_valid) begin
        n_valid++;
        check("key_valid_one_cycle", prev_kv, 1'b0);
        check("key_valid_expected", key_q.size() > 0, 1'b1);
        if (key_q.size() > 0) begin
          cmp_k  = key_q.pop_front();
          m_code = cmp_k.code;
          m_kbrk = cmp_k.brk;
          m_kext = cmp_k.ext;
        end
      end
      if (frame_err) begin
        n_err++;
        check("frame_err_expected", err_pending > 0, 1'b1);
        if (err_pending > 0) err_pending--;
      end
      check("ps2_received", ps2_received, m_code);
      check("key_break", key_break, m_kbrk);
      check("key_ext", key_ext, m_kext);
      prev_kv <= key_valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive nbits of a frame (11 = complete). glitch_at inserts a 3-cycle low
  // pulse on ps2_clk in the high phase preceding that bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0, input int glitch_at = -1,
                            input int nbits = 11);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      cyc(HALF / 2);
      if (glitch_at == i) begin
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
      end
      cyc(HALF / 4);
      ps2_dat = bits[i];
      cyc(HALF / 4);
      ps2_clk = 1'b0;
      if (i == 10) model_frame(b, !bad_par && !bad_stop);
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    if (nbits == 11) begin
      cyc(HALF);
      check("events_drained", key_q.size(), 0);
      check("errors_drained", err_pending, 0);
    end
  endtask

  task automatic expect_outputs(input string tag, input logic [7:0] code, input bit brk,
                                input bit ext);
    @(negedge clock);
    check({tag, "_code"}, ps2_received, code);
    check({tag, "_break"}, key_break, brk);
    check({tag, "_ext"}, key_ext, ext);
  endtask

  task automatic apply_reset(input int n);
    skip_cmp = 1'b1;
    model_reset();
    resetn = 1'b0;
    cyc(n);
    resetn = 1'b1;
    skip_cmp = 1'b0;
  endtask

  int v0, e0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    cyc(3);
    apply_reset(1);
    @(negedge clock);
    check("rst_code", ps2_received, 8'h00);
    check("rst_valid", key_valid, 1'b0);
    check("rst_break", key_break, 1'b0);
    check("rst_ext", key_ext, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Plain make code.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C);
    check("t1_valid_count", n_valid - v0, 1);
    check("t1_err_count", n_err - e0, 0);
    expect_outputs("t1", 8'h1C, 1'b0, 1'b0);

    // Release.
    v0 = n_valid;
    send_frame(8'hF0); send_frame(8'h1C);
    check("t2_valid_count", n_valid - v0, 1);
    expect_outputs("t2", 8'h1C, 1'b1, 1'b0);

    // Extended release, both prefix orders.
    v0 = n_valid;
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check("t3_valid_count", n_valid - v0, 1);
    expect_outputs("t3a", 8'h75, 1'b1, 1'b1);
    send_frame(8'hF0); send_frame(8'hE0); send_frame(8'h6B);
    expect_outputs("t3b", 8'h6B, 1'b1, 1'b1);

    // Repeated prefixes are idempotent.
    send_frame(8'hF0); send_frame(8'hF0); send_frame(8'h1C);
    expect_outputs("t3c", 8'h1C, 1'b1, 1'b0);
    send_frame(8'hE0); send_frame(8'hE0); send_frame(8'h74);
    expect_outputs("t3d", 8'h74, 1'b0, 1'b1);

    // Bad parity, then bad stop: error pulse, outputs held.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("t4_valid_count", n_valid - v0, 0);
    check("t4_err_count", n_err - e0, 2);
    expect_outputs("t4_hold", 8'h74, 1'b0, 1'b1);

    // An error between prefix and code drops the prefix.
    v0 = n_valid;
    send_frame(8'hF0); send_frame(8'h1C, 1'b1, 1'b0); send_frame(8'h29);
    check("t4b_valid_count", n_valid - v0, 1);
    expect_outputs("t4b", 8'h29, 1'b0, 1'b0);

    // Boundary byte values pass through as ordinary codes.
    foreach (bytes_list[i]) begin
      send_frame(bytes_list[i]);
      expect_outputs("edge_byte", bytes_list[i], 1'b0, 1'b0);
    end

    // Clock glitches: while idle, and inside a frame.
    v0 = n_valid; e0 = n_err;
    ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(HALF);
    @(negedge clock);
    check("t5_idle_busy", busy, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 4);
    expect_outputs("t5_glitched", 8'h5A, 1'b0, 1'b0);
    send_frame(8'h1C);
    expect_outputs("t5_clean", 8'h1C, 1'b0, 1'b0);
    check("t5_valid_count", n_valid - v0, 2);
    check("t5_err_count", n_err - e0, 0);

    // Reset in the middle of a frame.
    send_frame(8'h33, 1'b0, 1'b0, -1, 5);
    @(negedge clock);
    check("t6_busy_mid", busy, 1'b1);
    cyc(2);
    apply_reset(2);
    @(negedge clock);
    check("t6_rst_code", ps2_received, 8'h00);
    check("t6_rst_busy", busy, 1'b0);
    v0 = n_valid; e0 = n_err;
    send_frame(8'h1C);
    check("t6_valid_count", n_valid - v0, 1);
    check("t6_err_count", n_err - e0, 0);
    expect_outputs("t6", 8'h1C, 1'b0, 1'b0);

`ifdef PS2_TIMEOUT_EN
    // Stalled frame: aborted after the timeout, prefix dropped, link recovers.
    send_frame(8'hF0);
    e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b0, -1, 5);
    err_pending++;
    m_ext = 1'b0;
    m_brk = 1'b0;
    cyc(TO_CYC / 2);
    check("to_busy_waiting", busy, 1'b1);
    check("to_no_early_err", n_err - e0, 0);
    cyc(TO_CYC);
    check("to_err_count", n_err - e0, 1);
    check("to_busy_cleared", busy, 1'b0);
    check("to_err_consumed", err_pending, 0);
    send_frame(8'h29);
    expect_outputs("to_recover", 8'h29, 1'b0, 1'b0);
`endif

    cyc(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  logic [7:0] bytes_list[3] = '{8'h00, 8'hFF, 8'hAA};

endmodule
